// File: rtl/muon_trig_gen.sv
// Muon trigger generator: per-channel discriminators, coincidence stretch,
// and per-trigger edge/holdoff firing with 16-bit fire counters (3-clock latency).
module muon_trig_gen #(
    parameter int ADC_WIDTH = 12,
    parameter int NUM_TRIGS = 4
) (
    input  logic                 CLK120,
    input  logic                 RESET,
    input  logic [ADC_WIDTH-1:0] ADC0,
    input  logic [ADC_WIDTH-1:0] ADC1,
    input  logic [ADC_WIDTH-1:0] ADC2,
    input  logic [ADC_WIDTH-1:0] ADC_SSD,
    input  logic [ADC_WIDTH-1:0] MUON_THR0,
    input  logic [ADC_WIDTH-1:0] MUON_THR1,
    input  logic [ADC_WIDTH-1:0] MUON_THR2,
    input  logic [ADC_WIDTH-1:0] MUON_THR3,
    input  logic [3:0]           MUON_TRIG_WINDOW,
    input  logic [31:0]          MUON_TRIG1_CFG,
    input  logic [31:0]          MUON_TRIG2_CFG,
    input  logic [31:0]          MUON_TRIG3_CFG,
    input  logic [31:0]          MUON_TRIG4_CFG,
    input  logic                 MUON_CNT_CLR,
    output logic [NUM_TRIGS-1:0] MUON_TRIG_OUT,
    output logic [15:0]          MUON_TRIG_CNT1,
    output logic [15:0]          MUON_TRIG_CNT2,
    output logic [15:0]          MUON_TRIG_CNT3,
    output logic [15:0]          MUON_TRIG_CNT4
);
    localparam int NCH = 4;
    localparam int NTR = 4;

    logic [ADC_WIDTH-1:0] adc [NCH];
    logic [ADC_WIDTH-1:0] thr [NCH];
    logic [31:0]          cfg [NTR];
    logic                 cfg_unused;

    assign adc[0] = ADC0;
    assign adc[1] = ADC1;
    assign adc[2] = ADC2;
    assign adc[3] = ADC_SSD;
    assign thr[0] = MUON_THR0;
    assign thr[1] = MUON_THR1;
    assign thr[2] = MUON_THR2;
    assign thr[3] = MUON_THR3;
    assign cfg[0] = MUON_TRIG1_CFG;
    assign cfg[1] = MUON_TRIG2_CFG;
    assign cfg[2] = MUON_TRIG3_CFG;
    assign cfg[3] = MUON_TRIG4_CFG;
    assign cfg_unused = ^{MUON_TRIG1_CFG[31:16], MUON_TRIG2_CFG[31:16],
                          MUON_TRIG3_CFG[31:16], MUON_TRIG4_CFG[31:16]};

    logic [NCH-1:0] above_q;
    logic [NCH-1:0] stretch_q;
    logic [3:0]     win_q [NCH];

    always_ff @(posedge CLK120) begin
        if (RESET) begin
            above_q   <= '0;
            stretch_q <= '0;
            for (int c = 0; c < NCH; c++) win_q[c] <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                above_q[c]   <= adc[c] > thr[c];
                stretch_q[c] <= above_q[c] | (win_q[c] != 4'd0);
                if (above_q[c])
                    win_q[c] <= MUON_TRIG_WINDOW;
                else if (win_q[c] != 4'd0)
                    win_q[c] <= win_q[c] - 4'd1;
            end
        end
    end

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    logic [NTR-1:0] cond;
    logic [NTR-1:0] fire;
    logic [NTR-1:0] cond_prev_q;
    logic [NTR-1:0] fire_q;
    logic [7:0]     hold_q [NTR];
    logic [15:0]    cnt_q [NTR];

    // Fire only on a rising COND edge seen while holdoff is idle.
    always_comb begin
        cond = '0;
        fire = '0;
        for (int i = 0; i < NTR; i++) begin
            cond[i] = cfg[i][7] && (cfg[i][6:4] != 3'd0) &&
                      (popcount4(stretch_q & cfg[i][3:0]) >= cfg[i][6:4]);
            fire[i] = cond[i] && !cond_prev_q[i] && (hold_q[i] == 8'd0);
        end
    end

    always_ff @(posedge CLK120) begin
        if (RESET) begin
            cond_prev_q <= '0;
            fire_q      <= '0;
            for (int i = 0; i < NTR; i++) begin
                hold_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            cond_prev_q <= cond;
            fire_q      <= fire;
            for (int i = 0; i < NTR; i++) begin
                if (fire[i])
                    hold_q[i] <= cfg[i][15:8];
                else if (hold_q[i] != 8'd0)
                    hold_q[i] <= hold_q[i] - 8'd1;
                if (MUON_CNT_CLR)
                    cnt_q[i] <= '0;
                else if (fire[i])
                    cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    for (genvar j = 0; j < NUM_TRIGS; j++) begin : g_out
        if (j < NTR) begin : g_used
            assign MUON_TRIG_OUT[j] = fire_q[j];
        end else begin : g_none
            assign MUON_TRIG_OUT[j] = 1'b0;
        end
    end

    assign MUON_TRIG_CNT1 = cnt_q[0];
    assign MUON_TRIG_CNT2 = cnt_q[1];
    assign MUON_TRIG_CNT3 = cnt_q[2];
    assign MUON_TRIG_CNT4 = cnt_q[3];
endmodule

// File: tb/tb_muon_trig_gen.sv
// Bench for muon_trig_gen: directed scenarios plus randomized traffic
// checked every clock against a sample-history reference model.
module tb_muon_trig_gen;
    localparam int W    = 12;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic          rst;
    logic          clr;
    logic [3:0]    win;
    logic [W-1:0]  adc [4];
    logic [W-1:0]  thr [4];
    logic [31:0]   cfg [4];
    logic [3:0]    trig_out;
    logic [15:0]   cnt1, cnt2, cnt3, cnt4;

    muon_trig_gen #(.ADC_WIDTH(W), .NUM_TRIGS(4)) dut (
        .CLK120(clk), .RESET(rst),
        .ADC0(adc[0]), .ADC1(adc[1]), .ADC2(adc[2]), .ADC_SSD(adc[3]),
        .MUON_THR0(thr[0]), .MUON_THR1(thr[1]),
        .MUON_THR2(thr[2]), .MUON_THR3(thr[3]),
        .MUON_TRIG_WINDOW(win),
        .MUON_TRIG1_CFG(cfg[0]), .MUON_TRIG2_CFG(cfg[1]),
        .MUON_TRIG3_CFG(cfg[2]), .MUON_TRIG4_CFG(cfg[3]),
        .MUON_CNT_CLR(clr),
        .MUON_TRIG_OUT(trig_out),
        .MUON_TRIG_CNT1(cnt1), .MUON_TRIG_CNT2(cnt2),
        .MUON_TRIG_CNT3(cnt3), .MUON_TRIG_CNT4(cnt4)
    );

    // History of every applied input, indexed by the cycle it was applied.
    logic [W-1:0] adc_h [MAXC][4];
    logic [W-1:0] thr_h [MAXC][4];
    logic [31:0]  cfg_h [MAXC][4];
    logic [3:0]   win_h [MAXC];
    bit           rst_h [MAXC];
    bit           clr_h [MAXC];

    int cyc      = 0;
    int last_rst = 0;
    int next_ok [4];
    int cnt_m [4];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic bit above_f(input int k, input int c);
        if (k < 0 || k < last_rst) return 1'b0;
        return adc_h[k][c] > thr_h[k][c];
    endfunction

    function automatic bit stretch_f(input int k, input int c);
        for (int j = 0; j < 16; j++) begin
            if (k - j >= 0 && k - j >= last_rst && above_f(k - j, c) &&
                j <= int'(win_h[k - j + 1]))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit cond_f(input int k, input int i);
        logic [31:0] g;
        int p;
        if (k < 0 || k < last_rst) return 1'b0;
        g = cfg_h[k + 2][i];
        p = 0;
        for (int c = 0; c < 4; c++)
            if (g[c] && stretch_f(k, c)) p++;
        return g[7] && (g[6:4] != 3'd0) && (p >= int'(g[6:4]));
    endfunction

    task automatic model_and_check();
        int e, k;
        logic [3:0]  eo;
        logic [63:0] ec;
        e  = cyc;
        eo = '0;
        if (rst_h[e - 1]) begin
            last_rst = e;
            for (int i = 0; i < 4; i++) begin
                next_ok[i] = -100000;
                cnt_m[i]   = 0;
            end
        end else begin
            k = e - 3;
            for (int i = 0; i < 4; i++) begin
                if (cond_f(k, i) && !cond_f(k - 1, i) && k >= next_ok[i]) begin
                    eo[i]      = 1'b1;
                    next_ok[i] = k + int'(cfg_h[k + 2][i][15:8]) + 1;
                end
            end
            for (int i = 0; i < 4; i++)
                cnt_m[i] = clr_h[e - 1] ? 0 : (cnt_m[i] + int'(eo[i])) % 65536;
        end
        ec = {16'(cnt_m[3]), 16'(cnt_m[2]), 16'(cnt_m[1]), 16'(cnt_m[0])};
        n_cmp++;
        assert (trig_out === eo) else begin
            n_bad++;
            $error("FAIL model_out edge=%0d got=%h exp=%h", e, trig_out, eo);
        end
        n_cmp++;
        assert ({cnt4, cnt3, cnt2, cnt1} === ec) else begin
            n_bad++;
            $error("FAIL model_cnt edge=%0d got=%h exp=%h", e,
                   {cnt4, cnt3, cnt2, cnt1}, ec);
        end
    endtask

    task automatic tick();
        for (int c = 0; c < 4; c++) begin
            adc_h[cyc][c] = adc[c];
            thr_h[cyc][c] = thr[c];
            cfg_h[cyc][c] = cfg[c];
        end
        win_h[cyc] = win;
        rst_h[cyc] = rst;
        clr_h[cyc] = clr;
        @(posedge clk);
        cyc++;
        #1;
        model_and_check();
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pair(input int gap, output logic f);
        f = 1'b0;
        adc[0] = 12'd200;
        tick();
        f |= trig_out[1];
        adc[0] = 12'd0;
        for (int r = 1; r < gap; r++) begin
            tick();
            f |= trig_out[1];
        end
        adc[1] = 12'd200;
        tick();
        f |= trig_out[1];
        adc[1] = 12'd0;
        repeat (12) begin
            tick();
            f |= trig_out[1];
        end
    endtask

    function automatic logic [31:0] rand_cfg();
        logic [31:0] v;
        v       = $urandom;
        v[15:8] = 8'($urandom_range(0, 12));
        v[7]    = ($urandom_range(0, 3) != 0);
        v[6:4]  = 3'($urandom_range(0, 4));
        return v;
    endfunction

    logic [3:0] acc;
    logic       f;
    int         nf;

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        win = 4'd0;
        for (int c = 0; c < 4; c++) begin
            adc[c] = '0;
            thr[c] = 12'd100;
            cfg[c] = '0;
        end
        repeat (3) tick();
        chk("reset_out", trig_out, 0);
        chk("reset_cnt", {cnt4, cnt3, cnt2, cnt1}, 0);
        rst = 1'b0;

        // single channel, strict threshold, 3-clock latency
        cfg[0] = 32'h0000_0091;
        adc[0] = 12'd99;
        repeat (4) tick();
        adc[0] = 12'd101;
        tick();
        adc[0] = 12'd99;
        tick();
        chk("t1_edge2", trig_out, 0);
        tick();
        chk("t1_fire", trig_out, 4'b0001);
        tick();
        chk("t1_single", trig_out, 0);
        adc[0] = 12'd100;
        acc = '0;
        repeat (8) begin
            tick();
            acc |= trig_out;
        end
        chk("t1_equal_thr", acc, 0);
        chk("t1_cnt", cnt1, 1);

        // two-fold coincidence with stretch window 3
        adc[0] = 12'd0;
        cfg[0] = '0;
        cfg[1] = 32'h0000_00A3;
        win    = 4'd3;
        repeat (20) tick();
        pair(3, f);
        chk("t2_gap3", f, 1);
        pair(5, f);
        chk("t2_gap5", f, 0);

        // holdoff 10 with pulses at 0, 5, 20
        win    = 4'd0;
        cfg[1] = '0;
        cfg[0] = 32'h0000_0A91;
        clr    = 1'b1;
        tick();
        clr    = 1'b0;
        repeat (5) tick();
        nf = 0;
        for (int r = 0; r < 30; r++) begin
            adc[0] = (r == 0 || r == 5 || r == 20) ? 12'd200 : 12'd0;
            tick();
            if (trig_out[0]) nf++;
        end
        chk("t3_fires", nf, 2);
        chk("t3_cnt", cnt1, 2);

        // clear coincident with a fire
        repeat (15) tick();
        cfg[0] = 32'h0000_0091;
        for (int r = 0; r < 40; r++) begin
            adc[0] = (r % 2 == 0) ? 12'd200 : 12'd0;
            clr    = (r == 30);
            tick();
            if (r == 30) begin
                chk("t4_fire_at_clr", trig_out[0], 1);
                chk("t4_clr_wins", cnt1, 0);
            end
        end
        clr    = 1'b0;
        adc[0] = 12'd0;

        // all four triggers fire together
        repeat (15) tick();
        for (int i = 0; i < 4; i++) cfg[i] = 32'h0000_0091;
        adc[0] = 12'd200;
        tick();
        adc[0] = 12'd0;
        tick();
        tick();
        chk("t5_all", trig_out, 4'hF);

        // reset during holdoff with input held high
        for (int i = 1; i < 4; i++) cfg[i] = '0;
        cfg[0] = 32'h0000_3291;
        repeat (15) tick();
        adc[0] = 12'd200;
        repeat (6) tick();
        rst = 1'b1;
        repeat (2) tick();
        chk("t6_in_rst", trig_out, 0);
        rst = 1'b0;
        tick();
        chk("t6_rel1", trig_out, 0);
        tick();
        chk("t6_rel2", trig_out, 0);
        tick();
        chk("t6_refire", trig_out, 4'b0001);
        acc = '0;
        repeat (10) begin
            tick();
            acc |= trig_out;
        end
        chk("t6_hold", acc, 0);
        adc[0] = 12'd0;

        // randomized segments; window and thresholds change only when quiet
        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < 4; c++) adc[c] = '0;
            repeat (20) tick();
            win = 4'($urandom_range(0, 7));
            for (int c = 0; c < 4; c++) thr[c] = 12'($urandom_range(0, 4094));
            for (int i = 0; i < 4; i++) cfg[i] = rand_cfg();
            for (int r = 0; r < 120; r++) begin
                if ($urandom_range(0, 15) == 0)
                    cfg[$urandom_range(0, 3)] = rand_cfg();
                for (int c = 0; c < 4; c++) begin
                    case ($urandom_range(0, 3))
                        0: adc[c] = thr[c] + 12'd1;
                        1: adc[c] = thr[c];
                        2: adc[c] = 12'($urandom_range(0, 4095));
                        default: adc[c] = '0;
                    endcase
                end
                clr = ($urandom_range(0, 40) == 0);
                rst = ($urandom_range(0, 150) == 0);
                tick();
            end
            clr = 1'b0;
            rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
